// File: rtl/wb_arbiter2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter2_pkg
//  Purpose  : Shared definitions for the two-master Wishbone arbiter: one-hot
//             arbiter states, Wishbone width defaults, and the round-robin
//             tie-break helper.
//  Revision : 1.0  initial release
// ============================================================================
package wb_arbiter2_pkg;

    // Wishbone width defaults shared by bus blocks
    localparam int WB_ADR_W_DEFAULT = 32;
    localparam int WB_DAT_W_DEFAULT = 32;

    // One-hot state bit positions
    localparam int ST_IDLE_BIT  = 0;
    localparam int ST_OWN0_BIT  = 1;
    localparam int ST_OWN1_BIT  = 2;
    localparam int ST_ABORT_BIT = 3;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001 << ST_IDLE_BIT,
        ST_OWN0  = 4'b0001 << ST_OWN0_BIT,
        ST_OWN1  = 4'b0001 << ST_OWN1_BIT,
        ST_ABORT = 4'b0001 << ST_ABORT_BIT
    } arb_state_t;

    // Returns 1 when m1 should win arbitration: m1 requests and either m0 is
    // idle or m0 was the master served most recently.
    function automatic logic pick_m1(input logic cyc0, input logic cyc1,
                                     input logic last_was_m1);
        return cyc1 & (~cyc0 | ~last_was_m1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_arbiter2_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter2_watchdog
//  Purpose  : No-ack watchdog. Counts consecutive cycles with a strobe
//             outstanding and no slave response; flags the terminal cycle.
//  Revision : 1.0  initial release
// ============================================================================
module wb_arbiter2_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,      // synchronous, active-low
    input  logic count_en,   // strobe high with neither ack nor err this cycle
    output logic terminal    // this is the TIMEOUT_CYCLES-th waiting cycle
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    // Count waiting cycles; any response or strobe drop clears the count
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + CNT_W'(1);
        end else begin
            count <= '0;
        end
    end

    assign terminal = count_en && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/wb_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter2
//  Purpose  : Two-master / one-slave Wishbone classic arbiter. Round-robin
//             registered grant, owner-only ack/err/data routing, and a
//             no-ack watchdog that aborts hung cycles with an error pulse.
//  Revision : 1.0  initial release
// ============================================================================
module wb_arbiter2
    import wb_arbiter2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADR_W          = WB_ADR_W_DEFAULT,
    parameter int DAT_W          = WB_DAT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    // master 0
    input  logic               m0_cyc_i,
    input  logic               m0_stb_i,
    input  logic               m0_we_i,
    input  logic [DAT_W/8-1:0] m0_sel_i,
    input  logic [ADR_W-1:0]   m0_adr_i,
    input  logic [DAT_W-1:0]   m0_dat_i,
    output logic [DAT_W-1:0]   m0_dat_o,
    output logic               m0_ack_o,
    output logic               m0_err_o,
    // master 1
    input  logic               m1_cyc_i,
    input  logic               m1_stb_i,
    input  logic               m1_we_i,
    input  logic [DAT_W/8-1:0] m1_sel_i,
    input  logic [ADR_W-1:0]   m1_adr_i,
    input  logic [DAT_W-1:0]   m1_dat_i,
    output logic [DAT_W-1:0]   m1_dat_o,
    output logic               m1_ack_o,
    output logic               m1_err_o,
    // slave
    output logic               s_cyc_o,
    output logic               s_stb_o,
    output logic               s_we_o,
    output logic [DAT_W/8-1:0] s_sel_o,
    output logic [ADR_W-1:0]   s_adr_o,
    output logic [DAT_W-1:0]   s_dat_o,
    input  logic [DAT_W-1:0]   s_dat_i,
    input  logic               s_ack_i,
    input  logic               s_err_i,
    // status
    output logic [1:0]         grant_o,
    output logic               timeout_o
);

    arb_state_t state;
    logic       last_m1;      // 1 when m1 was the master served most recently

    logic       own0;
    logic       own1;
    logic       busy;
    logic       owner_cyc;
    logic       owner_stb;
    logic       owner_we;
    logic [DAT_W/8-1:0] owner_sel;
    logic [ADR_W-1:0]   owner_adr;
    logic [DAT_W-1:0]   owner_dat;
    logic       ack_fwd;
    logic       err_fwd;
    logic       wd_en;
    logic       wd_term;

    assign own0 = (state == ST_OWN0);
    assign own1 = (state == ST_OWN1);
    assign busy = own0 | own1;

    // Owner select comes only from the registered grant (held through ABORT),
    // so the non-owner's inputs never reach the slave combinationally.
    assign owner_cyc = grant_o[1] ? m1_cyc_i : m0_cyc_i;
    assign owner_stb = grant_o[1] ? m1_stb_i : m0_stb_i;
    assign owner_we  = grant_o[1] ? m1_we_i  : m0_we_i;
    assign owner_sel = grant_o[1] ? m1_sel_i : m0_sel_i;
    assign owner_adr = grant_o[1] ? m1_adr_i : m0_adr_i;
    assign owner_dat = grant_o[1] ? m1_dat_i : m0_dat_i;

    // Slave side: driven only while a master owns the bus (not in ABORT)
    assign s_cyc_o = busy & owner_cyc;
    assign s_stb_o = s_cyc_o & owner_stb;
    assign s_we_o  = busy & owner_we;
    assign s_sel_o = busy ? owner_sel : '0;
    assign s_adr_o = busy ? owner_adr : '0;
    assign s_dat_o = busy ? owner_dat : '0;

    // Slave response qualified by an active strobe; err beats ack
    assign ack_fwd = s_stb_o & s_ack_i & ~s_err_i;
    assign err_fwd = s_stb_o & s_err_i;
    assign wd_en   = s_stb_o & ~s_ack_i & ~s_err_i;

    wb_arbiter2_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .count_en (wd_en),
        .terminal (wd_term)
    );

    assign timeout_o = wd_term;

    // Master side: only the owner sees ack/err/data, others get zeros
    assign m0_ack_o = own0 & ack_fwd;
    assign m1_ack_o = own1 & ack_fwd;
    assign m0_err_o = own0 & (err_fwd | wd_term);
    assign m1_err_o = own1 & (err_fwd | wd_term);
    assign m0_dat_o = own0 ? s_dat_i : '0;
    assign m1_dat_o = own1 ? s_dat_i : '0;

    // Ownership FSM: round-robin grant, release on owner cyc drop, abort on timeout
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            grant_o <= 2'b00;
            last_m1 <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m0_cyc_i || m1_cyc_i) begin
                        if (pick_m1(m0_cyc_i, m1_cyc_i, last_m1)) begin
                            state   <= ST_OWN1;
                            grant_o <= 2'b10;
                        end else begin
                            state   <= ST_OWN0;
                            grant_o <= 2'b01;
                        end
                    end
                end
                ST_OWN0, ST_OWN1: begin
                    if (wd_term) begin
                        state <= ST_ABORT;
                    end else if (!owner_cyc) begin
                        state   <= ST_IDLE;
                        grant_o <= 2'b00;
                        last_m1 <= own1;
                    end
                end
                ST_ABORT: begin
                    if (!owner_cyc) begin
                        state   <= ST_IDLE;
                        grant_o <= 2'b00;
                        last_m1 <= grant_o[1];
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    grant_o <= 2'b00;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_arbiter2
//  Purpose  : Self-checking bench for wb_arbiter2: directed scenarios with
//             literal expectations plus randomized traffic compared every
//             cycle against a bus-ownership reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_arbiter2;

    localparam int T = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        mcyc [2];
    logic        mstb [2];
    logic        mwe  [2];
    logic [3:0]  msel [2];
    logic [31:0] madr [2];
    logic [31:0] mdat [2];
    logic        s_ack, s_err;
    logic [31:0] s_din;

    logic [31:0] m0_dat, m1_dat, s_adr, s_dout;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        s_cyc, s_stb, s_we, tmo;
    logic [3:0]  s_sel;
    logic [1:0]  grant;

    wb_arbiter2 #(.TIMEOUT_CYCLES(T), .ADR_W(32), .DAT_W(32)) dut (
        .clk(clk), .reset(reset),
        .m0_cyc_i(mcyc[0]), .m0_stb_i(mstb[0]), .m0_we_i(mwe[0]), .m0_sel_i(msel[0]),
        .m0_adr_i(madr[0]), .m0_dat_i(mdat[0]), .m0_dat_o(m0_dat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_cyc_i(mcyc[1]), .m1_stb_i(mstb[1]), .m1_we_i(mwe[1]), .m1_sel_i(msel[1]),
        .m1_adr_i(madr[1]), .m1_dat_i(mdat[1]), .m1_dat_o(m1_dat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel), .s_adr_o(s_adr),
        .s_dat_o(s_dout), .s_dat_i(s_din), .s_ack_i(s_ack), .s_err_i(s_err),
        .grant_o(grant), .timeout_o(tmo)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model: who owns the bus ----------------
    int  own  = -1;   // -1 none, else master index
    bit  abrt = 1'b0; // owner timed out, waiting for it to drop cyc
    int  last = 1;    // master served most recently
    int  wd   = 0;    // cycles waited with strobe out and no response
    bit  done_ack [2] = '{1'b0, 1'b0};
    bit  done_err [2] = '{1'b0, 1'b0};

    logic        e_scyc, e_sstb, e_swe, e_to;
    logic [3:0]  e_ssel;
    logic [31:0] e_sadr, e_sdat;
    logic        e_ack [2];
    logic        e_err [2];
    logic [31:0] e_mdat [2];
    logic [1:0]  e_grant;

    function automatic void compute_exp();
        bit busy;
        int o;
        bit fin_ack, fin_err;
        busy    = (own >= 0) && !abrt;
        o       = (own == 1) ? 1 : 0;
        e_scyc  = busy && mcyc[o];
        e_sstb  = e_scyc && mstb[o];
        e_swe   = busy && mwe[o];
        e_ssel  = busy ? msel[o] : 4'h0;
        e_sadr  = busy ? madr[o] : 32'h0;
        e_sdat  = busy ? mdat[o] : 32'h0;
        fin_ack = e_sstb && s_ack && !s_err;
        fin_err = e_sstb && s_err;
        e_to    = e_sstb && !s_ack && !s_err && (wd == T - 1);
        for (int m = 0; m < 2; m++) begin
            e_ack[m]  = busy && (own == m) && fin_ack;
            e_err[m]  = (own == m) && (fin_err || e_to);
            e_mdat[m] = (busy && own == m) ? s_din : 32'h0;
        end
        e_grant = (own < 0) ? 2'b00 : ((own == 1) ? 2'b10 : 2'b01);
    endfunction

    // Advance the model at each rising edge from the inputs of the closing cycle
    always @(posedge clk) begin
        int nwd;
        compute_exp();
        for (int m = 0; m < 2; m++) begin
            done_ack[m] = e_ack[m];
            done_err[m] = e_err[m];
        end
        if (!reset) begin
            own = -1; abrt = 1'b0; last = 1; wd = 0;
        end else begin
            nwd = (e_sstb && !s_ack && !s_err && !e_to) ? wd + 1 : 0;
            if (own < 0) begin
                if (mcyc[0] && (!mcyc[1] || last == 1)) own = 0;
                else if (mcyc[1]) own = 1;
            end else if (!abrt) begin
                if (e_to) abrt = 1'b1;
                else if (!mcyc[own]) begin last = own; own = -1; end
            end else if (!mcyc[own]) begin
                last = own; own = -1; abrt = 1'b0;
            end
            wd = nwd;
        end
    end

    // Compare every DUT output against the model mid-cycle
    always @(negedge clk) begin
        if (check_en) begin
            compute_exp();
            chk("s_cyc",   64'(s_cyc),  64'(e_scyc));
            chk("s_stb",   64'(s_stb),  64'(e_sstb));
            chk("s_we",    64'(s_we),   64'(e_swe));
            chk("s_sel",   64'(s_sel),  64'(e_ssel));
            chk("s_adr",   64'(s_adr),  64'(e_sadr));
            chk("s_dat",   64'(s_dout), 64'(e_sdat));
            chk("m0_ack",  64'(m0_ack), 64'(e_ack[0]));
            chk("m1_ack",  64'(m1_ack), 64'(e_ack[1]));
            chk("m0_err",  64'(m0_err), 64'(e_err[0]));
            chk("m1_err",  64'(m1_err), 64'(e_err[1]));
            chk("m0_dat",  64'(m0_dat), 64'(e_mdat[0]));
            chk("m1_dat",  64'(m1_dat), 64'(e_mdat[1]));
            chk("grant",   64'(grant),  64'(e_grant));
            chk("timeout", 64'(tmo),    64'(e_to));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_txn(input int m);
        mwe[m]  = 1'($urandom_range(0, 1));
        msel[m] = 4'($urandom);
        madr[m] = $urandom;
        mdat[m] = $urandom;
    endtask

    int          gseq [$];
    logic [1:0]  pg;
    int          hang;

    initial begin
        reset = 1'b0;
        s_ack = 1'b0; s_err = 1'b0; s_din = 32'h0;
        for (int m = 0; m < 2; m++) begin
            mcyc[m] = 1'b1; mstb[m] = 1'b1; mwe[m] = 1'b0; msel[m] = 4'hF; mdat[m] = $urandom;
        end
        madr[0] = 32'h4000_0000;
        madr[1] = 32'h5000_0000;

        // Reset held 3 cycles with both masters requesting
        repeat (3) begin
            @(posedge clk); #2;
            check_en = 1'b1;
            chk("rst_grant",  64'(grant),  64'h0);
            chk("rst_s_cyc",  64'(s_cyc),  64'h0);
            chk("rst_m0_ack", 64'(m0_ack), 64'h0);
            chk("rst_m1_ack", 64'(m1_ack), 64'h0);
        end

        // Tie after reset: m0 wins, single read acked two cycles after stb
        reset = 1'b1;
        tick(); #1;
        chk("tie_grant", 64'(grant), 64'h1);
        chk("rd_stb",    64'(s_stb), 64'h1);
        chk("rd_adr",    64'(s_adr), 64'h4000_0000);
        tick();
        tick();
        s_ack = 1'b1; s_din = 32'hDEAD_BEEF; #1;
        chk("rd_m0_ack", 64'(m0_ack), 64'h1);
        chk("rd_m0_dat", 64'(m0_dat), 64'hDEAD_BEEF);
        chk("rd_m1_ack", 64'(m1_ack), 64'h0);
        tick();
        s_ack = 1'b0; mcyc[0] = 1'b0; mstb[0] = 1'b0;
        tick(); #1;
        chk("turn_idle", 64'(grant), 64'h0);
        tick(); #1;
        chk("turn_m1",   64'(grant), 64'h2);
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0; mcyc[1] = 1'b0; mstb[1] = 1'b0;
        tick();

        // Watchdog: m1 write never acked, m0 waits behind it
        mcyc[1] = 1'b1; mstb[1] = 1'b1; mwe[1] = 1'b1; madr[1] = 32'h5000_0010;
        tick();
        mcyc[0] = 1'b1; mstb[0] = 1'b1; mwe[0] = 1'b0;
        for (int k = 2; k <= T; k++) tick();
        #1;
        chk("to_m1_err", 64'(m1_err), 64'h1);
        chk("to_pulse",  64'(tmo),    64'h1);
        chk("to_m0_err", 64'(m0_err), 64'h0);
        tick(); #1;
        chk("abort_s_cyc", 64'(s_cyc), 64'h0);
        chk("abort_grant", 64'(grant), 64'h2);
        tick(); tick(); #1;
        chk("abort_hold",  64'(grant), 64'h2);
        mcyc[1] = 1'b0; mstb[1] = 1'b0; mwe[1] = 1'b0;
        tick(); #1;
        chk("abort_idle",  64'(grant), 64'h0);
        tick(); #1;
        chk("abort_m0",    64'(grant), 64'h1);

        // Reset while m0 owns with strobe high
        reset = 1'b0;
        tick();
        s_ack = 1'b1; #1;
        chk("mid_rst_s_cyc",  64'(s_cyc),  64'h0);
        chk("mid_rst_grant",  64'(grant),  64'h0);
        chk("mid_rst_m0_ack", 64'(m0_ack), 64'h0);
        s_ack = 1'b0; reset = 1'b1;
        mcyc[0] = 1'b0; mstb[0] = 1'b0;
        tick();

        // Starvation: both masters re-request as soon as they are done
        mcyc[0] = 1'b1; mstb[0] = 1'b1; mcyc[1] = 1'b1; mstb[1] = 1'b1;
        pg = 2'b00;
        for (int c = 0; c < 300 && gseq.size() < 10; c++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                if (mcyc[m] && done_ack[m]) begin
                    mcyc[m] = 1'b0; mstb[m] = 1'b0;
                end else if (!mcyc[m]) begin
                    mcyc[m] = 1'b1; mstb[m] = 1'b1; new_txn(m);
                end
            end
            compute_exp();
            s_ack = e_sstb; s_err = 1'b0; s_din = $urandom;
            #1;
            if (grant !== 2'b00 && pg === 2'b00) gseq.push_back(int'(grant));
            pg = grant;
        end
        chk("starve_count", 64'(gseq.size()), 64'd10);
        for (int i = 0; i < gseq.size(); i++)
            chk("starve_grant", 64'(gseq[i]), (i % 2 == 0) ? 64'h1 : 64'h2);

        // Randomized traffic with a sometimes-hung slave and rare resets
        hang = 0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            reset = ($urandom_range(0, 299) != 0);
            for (int m = 0; m < 2; m++) begin
                if (mcyc[m]) begin
                    if (done_err[m] || (done_ack[m] && $urandom_range(0, 2) != 0)) begin
                        mcyc[m] = 1'b0; mstb[m] = 1'b0;
                    end else if (done_ack[m]) begin
                        new_txn(m);
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    mcyc[m] = 1'b1; mstb[m] = 1'b1; new_txn(m);
                end
            end
            compute_exp();
            s_ack = 1'b0; s_err = 1'b0; s_din = $urandom;
            if (hang > 0) begin
                hang--;
            end else if (e_sstb) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 45)      s_ack = 1'b1;
                else if (r < 52) s_err = 1'b1;
                else if (r < 56) begin s_ack = 1'b1; s_err = 1'b1; end
                else if (r < 60) hang = $urandom_range(4, 12);
            end
        end

        tick();
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
